// File: rtl/fifo_arb_pkg.sv
// Shared encodings and statistics constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans last+1, last+2, ... (mod N_REQ)
// and returns the first requesting index that is not masked out.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] elig;
  logic [IDX_W-1:0] cand;

  assign elig = req & ~excl;

  // Walk the ring from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % N_REQ);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready
// requesters with bounded bursts. Optional per-requester beat counters: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wren,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  input  logic [$clog2(N_REQ)-1:0]  stat_sel,
  output logic [STAT_W-1:0]         stat_count
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              owner_valid;
  logic              beat;
  logic [IDX_W-1:0]  pick_last;
  logic [N_REQ-1:0]  pick_excl;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // While granted, the picker searches from the current owner and skips it,
  // so a handover can be decided in the same cycle as the release.
  always_comb begin
    owner_valid = req_valid[owner_q];
    beat        = (state_q == ST_GRANT) && owner_valid && !fifo_full;
    pick_last   = (state_q == ST_GRANT) ? owner_q : last_owner_q;
    pick_excl   = '0;
    if (state_q == ST_GRANT) pick_excl[owner_q] = 1'b1;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .last  (pick_last),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    req_ready  = '0;
    fifo_wren  = 1'b0;
    fifo_wdata = '0;
    if (state_q == ST_GRANT) begin
      req_ready[owner_q] = !fifo_full;
      fifo_wren          = beat;
      fifo_wdata         = data_arr[owner_q];
    end
  end

  assign busy     = (state_q == ST_GRANT);
  assign grant_id = busy ? owner_q : '0;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      default: begin
        if (beat) beat_cnt_d = beat_cnt_q + 1'b1;
        // A full FIFO stalls without releasing; only a spent burst or a
        // withdrawn owner hands the port on.
        if ((beat && beat_cnt_d == CNT_W'(MAX_BURST)) || !owner_valid) begin
          last_owner_d = owner_q;
          beat_cnt_d   = '0;
          if (pick_found)        owner_d = pick_idx;
          else if (!owner_valid) state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N_REQ];
  logic [STAT_W-1:0] stat_d [N_REQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? STAT_MAX : v + 1'b1;
  endfunction

  always_comb begin
    stat_d = stat_q;
    if (beat) stat_d[owner_q] = sat_inc(stat_q[owner_q]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_count = (int'(stat_sel) < N_REQ) ? stat_q[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected beats are queued per scenario
// and matched against every FIFO write the arbiter issues.
module tb_fifo_wr_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wren;
  logic [7:0]    fifo_wdata;
  logic [1:0]    grant_id;
  logic          busy;
  logic [1:0]    stat_sel;
  logic [15:0]   stat_count;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  logic [7:0] src [N][$];
  beat_t      exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input int id, input int n);
    for (int k = 0; k < n; k++) src[id].push_back(8'(id * 16 + k));
  endtask

  task automatic expect_beats(input int id, input int first, input int n);
    for (int k = first; k < first + n; k++) exp_q.push_back('{id: 2'(id), data: 8'(id * 16 + k)});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs(input bit full);
    for (int i = 0; i < N; i++) begin
      if (src[i].size() != 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
    fifo_full = full;
  endtask

  // Entered and left at posedge+1; outputs sampled at posedge+2.
  task automatic run(input int max_cyc, input int full_from, input int full_len,
                     input bit drain, output int gaps);
    beat_t e;
    bit    full;
    gaps = 0;
    for (int c = 0; c < max_cyc; c++) begin
      full = (c >= full_from) && (c < full_from + full_len);
      drive_inputs(full);
      #1;
      if (full) begin
        checks++;
        if (fifo_wren !== 1'b0 || req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL stall_gate: wren=%b ready=%b required wren=0 ready=0000", fifo_wren, req_ready);
        end
      end
      if (busy && !fifo_wren && !full && exp_q.size() != 0) gaps++;
      if (fifo_wren) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: id=%0d data=%h required no write", grant_id, fifo_wdata);
        end else begin
          e = exp_q.pop_front();
          if (grant_id !== e.id || fifo_wdata !== e.data) begin
            errors++;
            $display("FAIL beat_order: id=%0d data=%h required id=%0d data=%h",
                     grant_id, fifo_wdata, e.id, e.data);
          end
        end
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) void'(src[i].pop_front());
      end
      @(posedge clk);
      #1;
      if (drain && exp_q.size() == 0 && srcs_empty()) break;
    end
    if (drain && exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    stat_sel  = '0;
    for (int i = 0; i < N; i++) src[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_ready, fifo_wren, fifo_wdata, busy, grant_id, stat_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b wren=%b wdata=%h busy=%b gid=%0d stat=%h required all 0",
               req_ready, fifo_wren, fifo_wdata, busy, grant_id, stat_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_grant();
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A1;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wren !== 1'b0) begin
      errors++;
      $display("FAIL first_idle: busy=%b wren=%b required 0 0", busy, fifo_wren);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || fifo_wren !== 1'b1 || fifo_wdata !== 8'hA1 ||
        grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant: busy=%b wren=%b wdata=%h gid=%0d ready=%b required 1 1 a1 0 0001",
               busy, fifo_wren, fifo_wdata, grant_id, req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int gaps;
    do_reset();
    for (int i = 0; i < N; i++) begin
      load(i, 4);
      expect_beats(i, 0, 4);
    end
    run(60, -1, 0, 1'b1, gaps);
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL rr_handover_gaps: %0d idle cycles required 0", gaps);
    end
  endtask

  task automatic test_regrant();
    int gaps;
    do_reset();
    load(2, 6);
    expect_beats(2, 0, 6);
    run(40, -1, 0, 1'b1, gaps);
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL regrant_gaps: %0d idle cycles required 0", gaps);
    end
  endtask

  task automatic test_full_stall();
    int gaps;
    do_reset();
    load(2, 4);
    load(3, 1);
    expect_beats(2, 0, 4);
    expect_beats(3, 0, 1);
    run(40, 3, 3, 1'b1, gaps);
  endtask

  task automatic test_valid_drop();
    int gaps;
    do_reset();
    load(1, 2);
    load(3, 4);
    expect_beats(1, 0, 2);
    expect_beats(3, 0, 4);
    run(40, -1, 0, 1'b1, gaps);
    checks++;
    if (gaps !== 1) begin
      errors++;
      $display("FAIL drop_handover_gaps: %0d idle cycles required 1", gaps);
    end
  endtask

  task automatic test_reset_mid_burst();
    int gaps;
    do_reset();
    load(3, 4);
    expect_beats(3, 0, 2);
    run(3, -1, 0, 1'b0, gaps);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_beats: %0d outstanding required 0", exp_q.size());
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, fifo_wren, fifo_wdata, busy, grant_id, stat_count} !== '0) begin
      errors++;
      $display("FAIL midburst_reset: ready=%b wren=%b wdata=%h busy=%b gid=%0d stat=%h required all 0",
               req_ready, fifo_wren, fifo_wdata, busy, grant_id, stat_count);
    end
    do_reset();
    src[0].push_back(8'h05);
    src[3].push_back(8'h3A);
    exp_q.push_back('{id: 2'd0, data: 8'h05});
    exp_q.push_back('{id: 2'd3, data: 8'h3A});
    run(20, -1, 0, 1'b1, gaps);
  endtask

  task automatic test_stats();
`ifdef FIFO_ARB_STATS_EN
    int beats;
    logic [15:0] want;
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h0000_1100;
    stat_sel  = 2'd1;
    beats     = 0;
    for (int c = 0; c < 70010; c++) begin
      #1;
      if (fifo_wren) beats++;
      @(posedge clk);
      #1;
      if (c == 100) begin
        want = 16'(beats);
        checks++;
        if (stat_count !== want) begin
          errors++;
          $display("FAIL stat_partial: got %h required %h", stat_count, want);
        end
      end
    end
    req_valid = '0;
    want = (beats >= 65535) ? 16'hFFFF : 16'(beats);
    checks++;
    if (stat_count !== want || beats < 70000) begin
      errors++;
      $display("FAIL stat_saturate: got %h after %0d beats required %h", stat_count, beats, want);
    end
    stat_sel = 2'd0;
    #1;
    checks++;
    if (stat_count !== 16'h0000) begin
      errors++;
      $display("FAIL stat_other: got %h required 0000", stat_count);
    end
`else
    for (int s = 0; s < N; s++) begin
      stat_sel = 2'(s);
      #1;
      checks++;
      if (stat_count !== 16'h0000) begin
        errors++;
        $display("FAIL stat_disabled sel=%0d: got %h required 0000", s, stat_count);
      end
    end
`endif
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    stat_sel  = '0;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_regrant();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
